// File: rtl/gpr_pkg.sv
// Shared definitions for the general-purpose register file slice.
// Holds default sizes, the default-width address/data typedefs and the
// hardwired-zero register index. No ports.
package gpr_pkg;

  localparam int unsigned XLEN_DEF    = 32;
  localparam int unsigned NR_REGS_DEF = 32;
  // Register count for RV32E builds.
  localparam int unsigned NR_REGS_E   = 16;
  localparam int unsigned AW_DEF      = $clog2(NR_REGS_DEF);

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] xlen_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/gpr_scoreboard.sv
// Per-register busy scoreboard for the register file.
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   iss_valid, iss_rd   issuing instruction with RegW=1 and its destination (sets busy)
//   wb_en, wb_addr      write-back enable and destination (clears busy)
//   rs1_addr, rs2_addr  decode read addresses
//   rs1_busy, rs2_busy  pending-write flags for the read addresses
//   any_busy            OR of all busy bits
// Optional feature macro: GPR_BYPASS_EN masks the busy of a register being written back.
module gpr_scoreboard #(
  parameter  int unsigned NR_REGS = 32,
  localparam int unsigned AW      = $clog2(NR_REGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          iss_valid,
  input  logic [AW-1:0] iss_rd,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [AW-1:0] rs1_addr,
  input  logic [AW-1:0] rs2_addr,
  output logic          rs1_busy,
  output logic          rs2_busy,
  output logic          any_busy
);

  logic [NR_REGS-1:0] busy_q, busy_d;
  logic               wb_hit;
  logic               iss_hit;

  assign wb_hit  = wb_en && (wb_addr != '0);
  assign iss_hit = iss_valid && (iss_rd != '0);

  // Clear first, then set, so a same-cycle set on the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (wb_hit) begin
      busy_d[wb_addr] = 1'b0;
    end
    if (iss_hit) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

`ifdef GPR_BYPASS_EN
  // Write-back in this cycle resolves the hazard, so hide the bit being cleared.
  assign rs1_busy = busy_q[rs1_addr] && !(wb_hit && (wb_addr == rs1_addr));
  assign rs2_busy = busy_q[rs2_addr] && !(wb_hit && (wb_addr == rs2_addr));
`else
  assign rs1_busy = busy_q[rs1_addr];
  assign rs2_busy = busy_q[rs2_addr];
`endif

  assign any_busy = |busy_q;

endmodule

// File: rtl/gpr_wb_regfile.sv
// General-purpose register file fed by the write-back stage.
// One write per cycle, two combinational decode read ports, one debug read port
// and a busy scoreboard for decode stalls. Entry 0 is hardwired to zero.
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   wb_en, wb_addr, wb_data     write-back request
//   rs1_addr/rs1_data/rs1_busy  read port 1
//   rs2_addr/rs2_data/rs2_busy  read port 2
//   iss_valid, iss_rd           issuing instruction destination (marks busy)
//   dbg_addr, dbg_data          debug/difftest read, never bypassed
//   any_busy                    any register has a pending write-back
// Optional feature macro: GPR_BYPASS_EN enables same-cycle write-to-read forwarding.
// NR_REGS must be a power of two.
module gpr_wb_regfile
  import gpr_pkg::*;
#(
  parameter  int unsigned XLEN    = XLEN_DEF,
  parameter  int unsigned NR_REGS = NR_REGS_DEF,
  localparam int unsigned AW      = $clog2(NR_REGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic [AW-1:0]   rs1_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic            rs1_busy,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs2_busy,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data,
  output logic            any_busy
);

  logic [XLEN-1:0] regs_q [NR_REGS];
  logic            wb_hit;

  assign wb_hit = wb_en && (wb_addr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NR_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_hit) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  logic [XLEN-1:0] rs1_arr, rs2_arr;

  assign rs1_arr  = (rs1_addr == '0) ? '0 : regs_q[rs1_addr];
  assign rs2_arr  = (rs2_addr == '0) ? '0 : regs_q[rs2_addr];
  assign dbg_data = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];

`ifdef GPR_BYPASS_EN
  // Forwarding is gated by reset so every read port shows 0 while in reset.
  always_comb begin
    rs1_data = rs1_arr;
    rs2_data = rs2_arr;
    if (rst_n && wb_hit && (wb_addr == rs1_addr)) begin
      rs1_data = wb_data;
    end
    if (rst_n && wb_hit && (wb_addr == rs2_addr)) begin
      rs2_data = wb_data;
    end
  end
`else
  assign rs1_data = rs1_arr;
  assign rs2_data = rs2_arr;
`endif

  gpr_scoreboard #(
    .NR_REGS (NR_REGS)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rs1_busy  (rs1_busy),
    .rs2_busy  (rs2_busy),
    .any_busy  (any_busy)
  );

endmodule

// File: tb/tb_gpr_wb_regfile.sv
module tb_gpr_wb_regfile;

  logic        clk;
  logic        rst_n;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [4:0]  rs1_addr;
  logic [31:0] rs1_data;
  logic        rs1_busy;
  logic [4:0]  rs2_addr;
  logic [31:0] rs2_data;
  logic        rs2_busy;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic        any_busy;

  int checks;
  int failures;

  gpr_wb_regfile #(
    .XLEN    (32),
    .NR_REGS (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .rs1_addr  (rs1_addr),
    .rs1_data  (rs1_data),
    .rs1_busy  (rs1_busy),
    .rs2_addr  (rs2_addr),
    .rs2_data  (rs2_data),
    .rs2_busy  (rs2_busy),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data),
    .any_busy  (any_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  rs1_a;
    logic [4:0]  rs2_a;
    logic [4:0]  dbg_a;
    logic [31:0] exp_rs1;
    logic [31:0] exp_rs2;
    logic [31:0] exp_dbg;
    logic        exp_b1;
    logic        exp_b2;
    logic        exp_any;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic iv, input logic [4:0] ir,
                              input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad,
                              input logic [31:0] e1, input logic [31:0] e2,
                              input logic [31:0] ed,
                              input logic b1, input logic b2, input logic ba);
    vec_t v;
    v.wb_en = we;  v.wb_addr = wa; v.wb_data = wd;
    v.iss_valid = iv; v.iss_rd = ir;
    v.rs1_a = a1; v.rs2_a = a2; v.dbg_a = ad;
    v.exp_rs1 = e1; v.exp_rs2 = e2; v.exp_dbg = ed;
    v.exp_b1 = b1; v.exp_b2 = b2; v.exp_any = ba;
    return v;
  endfunction

  // Drive one request for one edge, then drop the enables and check the settled state.
  task automatic apply(input vec_t v, input int idx);
    string tag;
    @(negedge clk);
    wb_en = v.wb_en; wb_addr = v.wb_addr; wb_data = v.wb_data;
    iss_valid = v.iss_valid; iss_rd = v.iss_rd;
    rs1_addr = v.rs1_a; rs2_addr = v.rs2_a; dbg_addr = v.dbg_a;
    @(posedge clk);
    #1;
    wb_en = 1'b0;
    iss_valid = 1'b0;
    #1;
    tag = $sformatf("vec%0d", idx);
    chk({tag, ".rs1_data"}, rs1_data, v.exp_rs1);
    chk({tag, ".rs2_data"}, rs2_data, v.exp_rs2);
    chk({tag, ".dbg_data"}, dbg_data, v.exp_dbg);
    chk({tag, ".rs1_busy"}, {31'b0, rs1_busy}, {31'b0, v.exp_b1});
    chk({tag, ".rs2_busy"}, {31'b0, rs2_busy}, {31'b0, v.exp_b2});
    chk({tag, ".any_busy"}, {31'b0, any_busy}, {31'b0, v.exp_any});
  endtask

  logic        bypass;
  logic [31:0] exp_old;

  initial begin
    checks   = 0;
    failures = 0;
`ifdef GPR_BYPASS_EN
    bypass = 1'b1;
`else
    bypass = 1'b0;
`endif

    //             we  wa     wd            iv  ir     rs1    rs2    dbg    e_rs1         e_rs2         e_dbg        b1 b2 any
    vecs[0] = mk(1, 5'd3,  32'hDEADBEEF, 0, 5'd0,  5'd3,  5'd0,  5'd3,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 0, 0, 0);
    vecs[1] = mk(1, 5'd0,  32'h00001234, 1, 5'd0,  5'd0,  5'd3,  5'd0,  32'h0,        32'hDEADBEEF, 32'h0,        0, 0, 0);
    vecs[2] = mk(0, 5'd0,  32'h0,        1, 5'd7,  5'd7,  5'd7,  5'd3,  32'h0,        32'h0,        32'hDEADBEEF, 1, 1, 1);
    vecs[3] = mk(1, 5'd7,  32'h00000055, 0, 5'd0,  5'd7,  5'd3,  5'd7,  32'h55,       32'hDEADBEEF, 32'h55,       0, 0, 0);
    vecs[4] = mk(0, 5'd0,  32'h0,        1, 5'd9,  5'd9,  5'd9,  5'd9,  32'h0,        32'h0,        32'h0,        1, 1, 1);
    vecs[5] = mk(1, 5'd9,  32'h000000A5, 1, 5'd9,  5'd9,  5'd9,  5'd9,  32'hA5,       32'hA5,       32'hA5,       1, 1, 1);
    vecs[6] = mk(1, 5'd9,  32'h00000077, 0, 5'd0,  5'd9,  5'd31, 5'd9,  32'h77,       32'h0,        32'h77,       0, 0, 0);
    vecs[7] = mk(1, 5'd31, 32'hFFFFFFFF, 1, 5'd12, 5'd31, 5'd12, 5'd31, 32'hFFFFFFFF, 32'h0,        32'hFFFFFFFF, 0, 1, 1);
    vecs[8] = mk(1, 5'd12, 32'h00000001, 0, 5'd0,  5'd12, 5'd31, 5'd12, 32'h1,        32'hFFFFFFFF, 32'h1,        0, 0, 0);

    // Reset held with clocks running and a write request pending.
    rst_n = 1'b0;
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h11111111;
    iss_valid = 1'b1; iss_rd = 5'd31;
    rs1_addr = 5'd5; rs2_addr = 5'd31; dbg_addr = 5'd5;
    repeat (2) @(posedge clk);
    #2;
    chk("rst.rs1_data", rs1_data, 32'h0);
    chk("rst.rs2_data", rs2_data, 32'h0);
    chk("rst.dbg_data", dbg_data, 32'h0);
    chk("rst.busy", {29'b0, rs1_busy, rs2_busy, any_busy}, 32'h0);
    wb_en = 1'b0; iss_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    chk("post_rst.rs1_data", rs1_data, 32'h0);
    chk("post_rst.rs2_data", rs2_data, 32'h0);
    chk("post_rst.any_busy", {31'b0, any_busy}, 32'h0);

    for (int i = 0; i < 9; i++) begin
      apply(vecs[i], i);
    end

    // Busy timing: set visible only after the issue edge; clear in the write-back cycle.
    @(negedge clk);
    iss_valid = 1'b1; iss_rd = 5'd7; rs2_addr = 5'd7;
    #1;
    chk("sb.pre_set_busy", {31'b0, rs2_busy}, 32'h0);
    @(posedge clk);
    #1;
    iss_valid = 1'b0;
    #1;
    chk("sb.set_busy", {31'b0, rs2_busy}, 32'h1);
    @(negedge clk);
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h66;
    #1;
    chk("sb.wb_cycle_busy", {31'b0, rs2_busy}, bypass ? 32'h0 : 32'h1);
    chk("sb.wb_cycle_data", rs2_data, bypass ? 32'h66 : 32'h55);
    @(posedge clk);
    #1;
    wb_en = 1'b0;
    #1;
    chk("sb.after_busy", {31'b0, rs2_busy}, 32'h0);
    chk("sb.after_any", {31'b0, any_busy}, 32'h0);
    chk("sb.after_data", rs2_data, 32'h66);

    // Same-cycle forwarding; debug port never forwards.
    @(negedge clk);
    wb_en = 1'b1; wb_addr = 5'd12; wb_data = 32'hCAFE;
    rs1_addr = 5'd12; dbg_addr = 5'd12;
    exp_old = 32'h1;
    #1;
    chk("byp.rs1_data", rs1_data, bypass ? 32'hCAFE : exp_old);
    chk("byp.dbg_data", dbg_data, exp_old);
    @(posedge clk);
    #1;
    wb_en = 1'b0;
    #1;
    chk("byp.after_rs1", rs1_data, 32'hCAFE);

    // Asynchronous reset between clock edges.
    @(negedge clk);
    iss_valid = 1'b1; iss_rd = 5'd4; rs1_addr = 5'd4; rs2_addr = 5'd12;
    @(posedge clk);
    #1;
    iss_valid = 1'b0;
    #1;
    chk("arst.pre_busy", {30'b0, rs1_busy, any_busy}, 32'h3);
    chk("arst.pre_data", rs2_data, 32'hCAFE);
    rst_n = 1'b0;
    #1;
    chk("arst.busy", {30'b0, rs1_busy, any_busy}, 32'h0);
    chk("arst.data", rs2_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    chk("arst.released_data", rs2_data, 32'h0);
    chk("arst.released_busy", {31'b0, rs1_busy}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
